// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline encodings and control-bundle layout for decode and execute
package id_ex_stage_pkg;
  localparam int REGW = 5;
  localparam int IMMW = 16;
  localparam int ALUW = 3;
  typedef enum logic [ALUW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluctr_t;
  typedef struct packed {
    logic    valid;
    logic    ext_op;
    logic    alusrc;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    memto_reg;
    aluctr_t aluctr;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic            valid_ex,
  input  logic            mem_read_ex,
  input  logic            reg_write_ex,
  input  logic [REGW-1:0] rt_ex,
  input  logic            valid_id,
  input  logic [REGW-1:0] rs_id,
  input  logic [REGW-1:0] rt_id,
  output logic            lu
);
  assign lu = valid_ex & mem_read_ex & reg_write_ex & valid_id & (rt_ex != '0) &
              ((rt_ex == rs_id) | (rt_ex == rt_id));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush, hold and stall counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_id,
  input  logic [REGW-1:0]  Rs_id,
  input  logic [REGW-1:0]  Rt_id,
  input  logic [REGW-1:0]  Rd_id,
  input  logic [WIDTH-1:0] BusA_id,
  input  logic [WIDTH-1:0] BusB_id,
  input  logic [IMMW-1:0]  imm16_id,
  input  logic             ExtOp_id,
  input  logic             Alusrc_id,
  input  logic             RegDst_id,
  input  logic             MemRead_id,
  input  logic             MemWrite_id,
  input  logic             RegWrite_id,
  input  logic             MemtoReg_id,
  input  logic [ALUW-1:0]  Aluctr_id,
  input  logic             Flush,
  input  logic             Hold,
  output logic             Stall,
  output logic             Valid_ex,
  output logic             ExtOp_ex,
  output logic             Alusrc_ex,
  output logic             MemRead_ex,
  output logic             MemWrite_ex,
  output logic             RegWrite_ex,
  output logic             MemtoReg_ex,
  output logic [ALUW-1:0]  Aluctr_ex,
  output logic [WIDTH-1:0] BusA_ex,
  output logic [WIDTH-1:0] BusB_ex,
  output logic [IMMW-1:0]  imm16_ex,
  output logic [REGW-1:0]  Rs_ex,
  output logic [REGW-1:0]  Rt_ex,
  output logic [REGW-1:0]  Rw_ex,
  output logic [CNTW-1:0]  StallCount
);
  ctrl_t ctrl_q, ctrl_d;
  logic  lu, load;
  hazard_detect u_hazard (
    .valid_ex    (ctrl_q.valid),
    .mem_read_ex (ctrl_q.mem_read),
    .reg_write_ex(ctrl_q.reg_write),
    .rt_ex       (Rt_ex),
    .valid_id    (Valid_id),
    .rs_id       (Rs_id),
    .rt_id       (Rt_id),
    .lu          (lu)
  );
  assign Stall = Hold | (lu & ~Flush);
  // flush, load-use and empty ID all collapse to a fully zeroed bubble
  assign load  = Valid_id & ~Flush & ~lu;
  always_comb begin
    ctrl_d = load ? ctrl_t'{valid: 1'b1, ext_op: ExtOp_id, alusrc: Alusrc_id,
                            mem_read: MemRead_id, mem_write: MemWrite_id,
                            reg_write: RegWrite_id, memto_reg: MemtoReg_id,
                            aluctr: aluctr_t'(Aluctr_id)} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      BusA_ex    <= '0;
      BusB_ex    <= '0;
      imm16_ex   <= '0;
      Rs_ex      <= '0;
      Rt_ex      <= '0;
      Rw_ex      <= '0;
      StallCount <= '0;
    end else if (!Hold) begin
      ctrl_q   <= ctrl_d;
      BusA_ex  <= load ? BusA_id : '0;
      BusB_ex  <= load ? BusB_id : '0;
      imm16_ex <= load ? imm16_id : '0;
      Rs_ex    <= load ? Rs_id : '0;
      Rt_ex    <= load ? Rt_id : '0;
      Rw_ex    <= load ? (RegDst_id ? Rd_id : Rt_id) : '0;
      if (lu && !Flush && !(&StallCount)) StallCount <= StallCount + CNTW'(1);
    end
  end
  assign Valid_ex    = ctrl_q.valid;
  assign ExtOp_ex    = ctrl_q.ext_op;
  assign Alusrc_ex   = ctrl_q.alusrc;
  assign MemRead_ex  = ctrl_q.mem_read;
  assign MemWrite_ex = ctrl_q.mem_write;
  assign RegWrite_ex = ctrl_q.reg_write;
  assign MemtoReg_ex = ctrl_q.memto_reg;
  assign Aluctr_ex   = ctrl_q.aluctr;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against an instruction-level model
module tb_id_ex_stage;
  localparam int W  = 32;
  localparam int CW = 2;
  logic clk = 0, rst = 1, Valid_id = 0, Flush = 0, Hold = 0;
  logic [4:0] Rs_id = 0, Rt_id = 0, Rd_id = 0;
  logic [W-1:0] BusA_id = 0, BusB_id = 0;
  logic [15:0] imm16_id = 0;
  logic ExtOp_id = 0, Alusrc_id = 0, RegDst_id = 0, MemRead_id = 0, MemWrite_id = 0;
  logic RegWrite_id = 0, MemtoReg_id = 0;
  logic [2:0] Aluctr_id = 0;
  logic Stall, Valid_ex, ExtOp_ex, Alusrc_ex, MemRead_ex, MemWrite_ex, RegWrite_ex, MemtoReg_ex;
  logic [2:0] Aluctr_ex;
  logic [W-1:0] BusA_ex, BusB_ex;
  logic [15:0] imm16_ex;
  logic [4:0] Rs_ex, Rt_ex, Rw_ex;
  logic [CW-1:0] StallCount;
  always #5 clk = ~clk;
  id_ex_stage #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .Valid_id(Valid_id), .Rs_id(Rs_id), .Rt_id(Rt_id), .Rd_id(Rd_id),
    .BusA_id(BusA_id), .BusB_id(BusB_id), .imm16_id(imm16_id), .ExtOp_id(ExtOp_id),
    .Alusrc_id(Alusrc_id), .RegDst_id(RegDst_id), .MemRead_id(MemRead_id),
    .MemWrite_id(MemWrite_id), .RegWrite_id(RegWrite_id), .MemtoReg_id(MemtoReg_id),
    .Aluctr_id(Aluctr_id), .Flush(Flush), .Hold(Hold), .Stall(Stall), .Valid_ex(Valid_ex),
    .ExtOp_ex(ExtOp_ex), .Alusrc_ex(Alusrc_ex), .MemRead_ex(MemRead_ex),
    .MemWrite_ex(MemWrite_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
    .Aluctr_ex(Aluctr_ex), .BusA_ex(BusA_ex), .BusB_ex(BusB_ex), .imm16_ex(imm16_ex),
    .Rs_ex(Rs_ex), .Rt_ex(Rt_ex), .Rw_ex(Rw_ex), .StallCount(StallCount)
  );
  // one instruction as seen in EX: controls, data, register fields
  typedef struct packed {
    bit v, ext, alusrc, mr, mw, rw, m2r;
    bit [2:0] alu;
    bit [W-1:0] a, b;
    bit [15:0] imm;
    bit [4:0] rs, rt, dst;
  } ins_t;
  ins_t m;
  int cnt = 0;
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic ins_t id_ins();
    return ins_t'({Valid_id, ExtOp_id, Alusrc_id, MemRead_id, MemWrite_id, RegWrite_id,
                   MemtoReg_id, Aluctr_id, BusA_id, BusB_id, imm16_id, Rs_id, Rt_id,
                   RegDst_id ? Rd_id : Rt_id});
  endfunction
  function automatic ins_t ex_ins();
    return ins_t'({Valid_ex, ExtOp_ex, Alusrc_ex, MemRead_ex, MemWrite_ex, RegWrite_ex,
                   MemtoReg_ex, Aluctr_ex, BusA_ex, BusB_ex, imm16_ex, Rs_ex, Rt_ex, Rw_ex});
  endfunction
  function automatic bit uses_load();
    return m.v && m.mr && m.rw && Valid_id && m.rt != 0 && (m.rt == Rs_id || m.rt == Rt_id);
  endfunction
  task automatic step(input string tag);
    bit lu;
    #1;
    lu = uses_load();
    check({tag, "_stall"}, Stall, Hold || (lu && !Flush));
    @(posedge clk);
    #1;
    if (rst) begin
      m = '0;
      cnt = 0;
    end else if (!Hold) begin
      if (lu && !Flush) cnt = (cnt == 3) ? 3 : cnt + 1;
      m = (Flush || lu || !Valid_id) ? ins_t'(0) : id_ins();
    end
    check({tag, "_ex"}, ex_ins(), m);
    check({tag, "_cnt"}, StallCount, cnt);
  endtask
  task automatic set_id(input bit v, input bit mr, input bit rw, input int rs, input int rt,
                        input int rd, input bit rd_sel);
    Valid_id = v; MemRead_id = mr; RegWrite_id = rw;
    Rs_id = 5'(rs); Rt_id = 5'(rt); Rd_id = 5'(rd); RegDst_id = rd_sel;
    BusA_id = $urandom; BusB_id = $urandom; imm16_id = 16'($urandom);
    ExtOp_id = 1'($urandom); Alusrc_id = 1'($urandom); MemWrite_id = 1'($urandom);
    MemtoReg_id = 1'($urandom); Aluctr_id = 3'($urandom);
  endtask
  initial begin
    m = '0;
    step("reset");
    rst = 0;
    set_id(1, 0, 1, 3, 4, 5, 1);
    BusA_id = 32'h11; imm16_id = 16'h8000;
    step("normal");
    check("normal_rw", Rw_ex, 5);
    check("normal_busa", BusA_ex, 32'h11);
    check("normal_imm", imm16_ex, 16'h8000);
    check("normal_valid", Valid_ex, 1);
    set_id(1, 1, 1, 2, 8, 0, 0);
    step("lw");
    set_id(1, 0, 1, 8, 9, 10, 1);
    #1 check("lu_stall_now", Stall, 1);
    step("lu");
    check("lu_bubble", Valid_ex, 0);
    check("lu_count", StallCount, 1);
    step("lu_release");
    check("lu_add_in_ex", {Valid_ex, Rw_ex}, {1'b1, 5'd10});
    set_id(1, 1, 1, 2, 8, 0, 0);
    step("lw2");
    set_id(1, 0, 1, 8, 9, 10, 1);
    Flush = 1;
    step("flush_lu");
    check("flush_lu_count", StallCount, 1);
    Flush = 0;
    set_id(1, 0, 1, 6, 7, 12, 1);
    step("pre_hold");
    Hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 1'($urandom), 1, $urandom_range(0, 31), $urandom_range(0, 31), 3, 1);
      Flush = 1'($urandom);
      step("hold");
      check("hold_rw", Rw_ex, 12);
    end
    Hold = 0; Flush = 0;
    step("hold_release");
    for (int i = 0; i < 4; i++) begin
      set_id(1, 1, 1, 1, 8, 0, 0);
      step("sat_lw");
      set_id(1, 0, 1, 9, 8, 10, 1);
      step("sat_lu");
      step("sat_release");
    end
    check("saturated", StallCount, 3);
    set_id(1, 1, 1, 1, 0, 0, 0);
    step("lw_r0");
    set_id(1, 0, 1, 0, 0, 10, 1);
    #1 check("r0_no_stall", Stall, 0);
    step("r0_use");
    set_id(1, 1, 1, 4, 5, 6, 1);
    step("pre_reset");
    Hold = 1; rst = 1;
    step("reset_hold");
    check("reset_all_zero", {ex_ins(), StallCount}, 0);
    Hold = 0; rst = 0;
    for (int i = 0; i < 500; i++) begin
      set_id($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
             1'($urandom));
      Flush = $urandom_range(0, 6) == 0;
      Hold = $urandom_range(0, 6) == 0;
      rst = $urandom_range(0, 60) == 0;
      step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
